uart_periph: RTL and testbench

- Memory-mapped UART peripheral occupying the bus UART window (select code 3'b000, 6-bit register offset).
- It is the downstream consumer of the bus decoder's UART enable and sits alongside the I2C, QSPI, timer and GPIO register blocks.
- Bytes written by the core are buffered in a TX FIFO and serialised 8N1, LSB first, on tx_o.
- Frames received on rx_i are deserialised into an RX FIFO that the core drains by reading a data register.

---
 rtl/uart_periph.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_uart_periph.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_periph.sv
// Memory-mapped UART: register file, TX/RX byte FIFOs and 8N1 serialiser/deserialiser.
// Define UART_PARITY_EN to add an optional parity bit (CTRL[4] enable, CTRL[5] odd).

module uart_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] din_i,
  output logic [7:0] dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

module uart_periph #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] CPB_RESET  = 16'd868
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic        rd_i,
  input  logic [3:0]  be_i,
  input  logic [5:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        tx_o,
  input  logic        rx_i,
  output logic        irq_o
);
  localparam logic [5:0] A_CPB = 6'h00, A_CTRL = 6'h04, A_STAT = 6'h08, A_TDR = 6'h0C, A_RDR = 6'h10;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK} rx_state_e;

  logic [15:0] cpb_q, cpb_d;
  logic [5:0]  ctrl_q, ctrl_d;
  logic        ovr_q, ferr_q, perr_q, irq_q;
  logic [2:0]  w1c;
  logic        tdr_push;
  logic        parity_en, parity_odd;

`ifdef UART_PARITY_EN
  localparam logic [5:0] CTRL_MASK = 6'h3F;
  assign parity_en  = ctrl_q[4];
  assign parity_odd = ctrl_q[5];
`else
  localparam logic [5:0] CTRL_MASK = 6'h0F;
  assign parity_en  = 1'b0;
  assign parity_odd = 1'b0;
`endif

  logic tx_en, rx_en;
  assign tx_en = ctrl_q[0];
  assign rx_en = ctrl_q[1];

  logic       tx_full, tx_empty, tx_pop, rx_full, rx_empty, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_bit_q, tx_bit_d;
  logic        tx_tick, tx_busy, start_frame;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic        rx_par_bad_q, rx_par_bad_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_tick;
  logic        set_ovr, set_ferr, set_perr;

  logic unused_bits;
  assign unused_bits = ^{be_i[3:2], wdata_i[31:16]};

  assign rx_pop = rd_i & (addr_i == A_RDR);

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(tdr_push), .pop_i(tx_pop), .din_i(wdata_i[7:0]),
    .dout_o(tx_head), .full_o(tx_full), .empty_o(tx_empty)
  );

  uart_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rst_i(rst_i), .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_shift_q),
    .dout_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );

  always_comb begin
    cpb_d    = cpb_q;
    ctrl_d   = ctrl_q;
    w1c      = '0;
    tdr_push = 1'b0;
    if (we_i) begin
      case (addr_i)
        A_CPB: begin
          if (be_i[0]) cpb_d[7:0]  = wdata_i[7:0];
          if (be_i[1]) cpb_d[15:8] = wdata_i[15:8];
          // Baud counters need at least a few clocks per bit for the half-bit sample.
          if (cpb_d < 16'd4) cpb_d = 16'd4;
        end
        A_CTRL:  if (be_i[0]) ctrl_d = wdata_i[5:0] & CTRL_MASK;
        A_STAT:  if (be_i[0]) w1c = wdata_i[7:5];
        A_TDR:   tdr_push = be_i[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (addr_i)
      A_CPB:   rdata_o = {16'b0, cpb_q};
      A_CTRL:  rdata_o = {26'b0, ctrl_q};
      A_STAT:  rdata_o = {24'b0, perr_q, ferr_q, ovr_q, tx_busy, rx_empty, rx_full, tx_empty, tx_full};
      A_RDR:   rdata_o = rx_empty ? 32'b0 : {24'b0, rx_head};
      default: rdata_o = '0;
    endcase
  end

  assign tx_tick = (tx_cnt_q == '0);
  assign tx_busy = (tx_state_q != TX_IDLE);
  assign tx_o    = tx_bit_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_data_d   = tx_data_q;
    tx_bit_d    = tx_bit_q;
    tx_pop      = 1'b0;
    start_frame = 1'b0;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? cpb_q - 16'd1 : tx_cnt_q - 16'd1;
    case (tx_state_q)
      TX_IDLE:  start_frame = tx_en & ~tx_empty;
      TX_START: if (tx_tick) begin
        tx_state_d = TX_DATA;
        tx_idx_d   = '0;
        tx_bit_d   = tx_data_q[0];
      end
      TX_DATA: if (tx_tick) begin
        if (tx_idx_q == 3'd7) begin
          if (parity_en) begin
            tx_state_d = TX_PAR;
            tx_bit_d   = (^tx_data_q) ^ parity_odd;
          end else begin
            tx_state_d = TX_STOP;
            tx_bit_d   = 1'b1;
          end
        end else begin
          tx_idx_d = tx_idx_q + 3'd1;
          tx_bit_d = tx_data_q[tx_idx_q + 3'd1];
        end
      end
      TX_PAR: if (tx_tick) begin
        tx_state_d = TX_STOP;
        tx_bit_d   = 1'b1;
      end
      TX_STOP: if (tx_tick) begin
        // Chain straight into the next start bit so bursts have no idle gap.
        if (tx_en && !tx_empty) start_frame = 1'b1;
        else tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    if (start_frame) begin
      tx_pop     = 1'b1;
      tx_data_d  = tx_head;
      tx_state_d = TX_START;
      tx_cnt_d   = cpb_q - 16'd1;
      tx_bit_d   = 1'b0;
    end
  end

  assign rx_tick = (rx_cnt_q == '0);

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_shift_d   = rx_shift_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push      = 1'b0;
    set_ovr      = 1'b0;
    set_ferr     = 1'b0;
    set_perr     = 1'b0;
    if (rx_state_q != RX_IDLE && rx_state_q != RX_BREAK)
      rx_cnt_d = rx_tick ? cpb_q - 16'd1 : rx_cnt_q - 16'd1;
    if (!rx_en) begin
      rx_state_d = RX_IDLE;
    end else begin
      case (rx_state_q)
        RX_IDLE: if (rx_prev_q && !rx_s2_q) begin
          rx_state_d   = RX_START;
          rx_cnt_d     = (cpb_q >> 1) - 16'd1;
          rx_par_bad_d = 1'b0;
        end
        RX_START: if (rx_tick) begin
          if (rx_s2_q) rx_state_d = RX_IDLE;
          else begin
            rx_state_d = RX_DATA;
            rx_idx_d   = '0;
          end
        end
        RX_DATA: if (rx_tick) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_idx_d   = rx_idx_q + 3'd1;
          if (rx_idx_q == 3'd7) rx_state_d = parity_en ? RX_PAR : RX_STOP;
        end
        RX_PAR: if (rx_tick) begin
          rx_par_bad_d = (((^rx_shift_q) ^ parity_odd) != rx_s2_q);
          rx_state_d   = RX_STOP;
        end
        RX_STOP: if (rx_tick) begin
          if (!rx_s2_q) begin
            set_ferr   = 1'b1;
            rx_state_d = RX_BREAK;
          end else begin
            rx_state_d = RX_IDLE;
            if (rx_par_bad_q)  set_perr = 1'b1;
            else if (rx_full)  set_ovr  = 1'b1;
            else               rx_push  = 1'b1;
          end
        end
        RX_BREAK: if (rx_s2_q) rx_state_d = RX_IDLE;
        default:  rx_state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cpb_q        <= CPB_RESET;
      ctrl_q       <= '0;
      ovr_q        <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      irq_q        <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_cnt_q     <= '0;
      tx_idx_q     <= '0;
      tx_data_q    <= '0;
      tx_bit_q     <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_idx_q     <= '0;
      rx_shift_q   <= '0;
      rx_par_bad_q <= 1'b0;
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
    end else begin
      cpb_q        <= cpb_d;
      ctrl_q       <= ctrl_d;
      ovr_q        <= (ovr_q & ~w1c[0]) | set_ovr;
      ferr_q       <= (ferr_q & ~w1c[1]) | set_ferr;
      perr_q       <= (perr_q & ~w1c[2]) | set_perr;
      irq_q        <= (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy);
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_idx_q     <= tx_idx_d;
      tx_data_q    <= tx_data_d;
      tx_bit_q     <= tx_bit_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_shift_q   <= rx_shift_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_s1_q      <= rx_i;
      rx_s2_q      <= rx_s1_q;
      rx_prev_q    <= rx_s2_q;
    end
  end

  assign irq_o = irq_q;
endmodule

// File: tb/tb_uart_periph.sv
// Scoreboard bench for uart_periph: register/pin expectations are queued by the
// stimulus and checked by a negedge monitor; a second monitor decodes tx_o frames.

module tb_uart_periph;
  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_i = 1'b0, rd_i = 1'b0, rx_i = 1'b1;
  logic [3:0]  be_i = '0;
  logic [5:0]  addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic [31:0] rdata_o;
  logic        tx_o, irq_o;

  int checks = 0;
  int errors = 0;
  int cur_cpb = 868;
  int tx_gaps = 0;
  logic chk_req = 1'b0;

  string       nm_q[$];
  int          kind_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];

  always #5 clk_i = ~clk_i;

  uart_periph #(.FIFO_DEPTH(8), .CPB_RESET(16'd868)) dut (
    .clk_i(clk_i), .rst_i(rst_n), .we_i(we_i), .rd_i(rd_i), .be_i(be_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rdata_o(rdata_o), .tx_o(tx_o), .rx_i(rx_i), .irq_o(irq_o)
  );

  // kind: 0 rdata, 1 irq_o, 2 tx_o, 3 tx gap count, 4 pending tx frames
  initial begin
    string       nm;
    int          kind;
    logic [31:0] exp, act;
    forever begin
      @(negedge clk_i);
      if (chk_req) begin
        checks++;
        if (nm_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
          nm = nm_q.pop_front();
          kind = kind_q.pop_front();
          exp = exp_q.pop_front();
          case (kind)
            0:       act = rdata_o;
            1:       act = {31'b0, irq_o};
            2:       act = {31'b0, tx_o};
            3:       act = tx_gaps;
            default: act = tx_exp_q.size();
          endcase
          if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
          end
        end
      end
    end
  end

  initial begin
    bit         in_frame = 0, after_frame = 0, fr_bad = 0;
    int         fr_idx = 0;
    logic [9:0] fr_bits = '0;
    logic [7:0] b;
    forever begin
      @(negedge clk_i);
      if (!rst_n) begin
        in_frame = 0;
        after_frame = 0;
      end else if (in_frame) begin
        if (tx_o !== fr_bits[fr_idx / cur_cpb]) fr_bad = 1;
        fr_idx++;
        if (fr_idx == 10 * cur_cpb) begin
          in_frame = 0;
          after_frame = (tx_exp_q.size() != 0);
          checks++;
          if (fr_bad) begin
            errors++;
            $display("FAIL tx_frame byte %h bit timing or level wrong at %0t", fr_bits[8:1], $time);
          end
        end
      end else if (tx_o === 1'b0) begin
        checks++;
        if (tx_exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected_frame got start bit expected idle at %0t", $time);
          b = 8'h00;
        end else b = tx_exp_q.pop_front();
        fr_bits = {1'b1, b, 1'b0};
        fr_idx = 1;
        fr_bad = 0;
        in_frame = 1;
      end else if (after_frame && tx_exp_q.size() != 0) begin
        tx_gaps++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  task automatic expect_item(input string nm, input int kind, input logic [31:0] exp);
    nm_q.push_back(nm);
    kind_q.push_back(kind);
    exp_q.push_back(exp);
    chk_req = 1'b1;
    @(posedge clk_i); #1;
    chk_req = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] exp, input string nm);
    addr_i = a;
    rd_i = 1'b1;
    expect_item(nm, 0, exp);
    rd_i = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_i = a;
    wdata_i = d;
    be_i = be;
    we_i = 1'b1;
    @(posedge clk_i); #1;
    we_i = 1'b0;
    be_i = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (cur_cpb) @(posedge clk_i);
      #1;
    end
    rx_i = 1'b1;
    idle(6);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;
    idle(1);
    rd(6'h08, 32'h0A, "reset_status");
    rd(6'h00, 32'd868, "reset_cpb");
    rd(6'h04, 32'h0, "reset_ctrl");
    expect_item("reset_irq", 1, 0);
    expect_item("reset_tx", 2, 1);
    rd(6'h10, 32'h0, "rdr_empty_reset");
    rd(6'h0C, 32'h0, "tdr_reads_zero");
    rd(6'h14, 32'h0, "unmapped_zero");

    wr(6'h00, 32'h2, 4'b0011);
    rd(6'h00, 32'h4, "cpb_min_clamp");
    wr(6'h00, 32'h0000_0100, 4'b0010);
    rd(6'h00, 32'h104, "cpb_byte_enable");
    wr(6'h00, 32'd16, 4'b0011);
    cur_cpb = 16;
    rd(6'h00, 32'd16, "cpb_16");

    // single frame 0xA5 and start-bit latency
    wr(6'h04, 32'h7, 4'b0001);
    tx_exp_q.push_back(8'hA5);
    wr(6'h0C, 32'hA5, 4'b0001);
    expect_item("tx_lat_1clk_high", 2, 1);
    expect_item("tx_lat_2clk_start", 2, 0);
    rd(6'h08, 32'h1A, "status_tx_busy");
    idle(165);
    rd(6'h08, 32'h0A, "status_tx_done");

    // nine writes into an 8-deep FIFO with TX disabled, then a burst
    wr(6'h04, 32'h6, 4'b0001);
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_exp_q.push_back(8'(i));
      wr(6'h0C, 32'(i), 4'b0001);
    end
    rd(6'h08, 32'h09, "status_tx_full");
    wr(6'h04, 32'h7, 4'b0001);
    idle(8 * 160 + 30);
    expect_item("tx_burst_gaps", 3, 0);
    expect_item("tx_burst_pending", 4, 0);
    rd(6'h08, 32'h0A, "status_after_burst");

    wr(6'h04, 32'hF, 4'b0001);
    idle(1);
    expect_item("irq_tx_empty", 1, 1);
    wr(6'h04, 32'h7, 4'b0001);
    idle(1);
    expect_item("irq_tx_off", 1, 0);

    // receive one frame
    send_rx(8'h3C, 1'b1);
    expect_item("irq_rx", 1, 1);
    rd(6'h08, 32'h02, "status_rx_data");
    rd(6'h10, 32'h3C, "rdr_3c");
    rd(6'h08, 32'h0A, "status_rx_drained");
    expect_item("irq_rx_clear", 1, 0);

    // fill RX FIFO, then overrun
    for (int i = 0; i < 8; i++) send_rx(8'h10 + 8'(i), 1'b1);
    send_rx(8'h99, 1'b1);
    rd(6'h08, 32'h26, "status_overrun");
    expect_item("irq_rx_full", 1, 1);
    wr(6'h08, 32'h20, 4'b0001);
    rd(6'h08, 32'h06, "status_ovr_w1c");
    for (int i = 0; i < 8; i++) rd(6'h10, 32'h10 + i, "rdr_fifo_kept");
    rd(6'h08, 32'h0A, "status_rx_empty_again");

    // framing error
    send_rx(8'h55, 1'b0);
    rd(6'h08, 32'h4A, "status_frame_err");
    rd(6'h10, 32'h0, "rdr_no_push_ferr");
    wr(6'h08, 32'h40, 4'b0001);
    rd(6'h08, 32'h0A, "status_ferr_w1c");

    // 3-clock glitch, then a good frame proves RX is idle again
    rx_i = 1'b0;
    idle(3);
    rx_i = 1'b1;
    idle(40);
    rd(6'h08, 32'h0A, "status_glitch");
    send_rx(8'h81, 1'b1);
    rd(6'h10, 32'h81, "rdr_after_glitch");

    // reset during a data bit
    tx_exp_q.push_back(8'hF0);
    wr(6'h0C, 32'hF0, 4'b0001);
    idle(40);
    #2 rst_n = 1'b0;
    cur_cpb = 868;
    expect_item("rst_tx_high", 2, 1);
    rst_n = 1'b1;
    idle(1);
    rd(6'h08, 32'h0A, "rst_status");
    rd(6'h00, 32'd868, "rst_cpb");
    rd(6'h04, 32'h0, "rst_ctrl");
    expect_item("rst_irq", 1, 0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
